// File: rtl/cpu_multi_cycle_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM states, trap causes and small decode/overflow helpers.
package cpu_multi_cycle_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] TRAP_NONE     = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL  = 2'd1;
    localparam logic [1:0] TRAP_OVF      = 2'd2;
    localparam logic [1:0] TRAP_MISALIGN = 2'd3;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_JR: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic add_ovf(input logic signed [XLEN-1:0] a,
                                     input logic signed [XLEN-1:0] b,
                                     input logic signed [XLEN-1:0] s);
        return (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [XLEN-1:0] a,
                                     input logic signed [XLEN-1:0] b,
                                     input logic signed [XLEN-1:0] d);
        return (a[XLEN-1] != b[XLEN-1]) && (d[XLEN-1] != a[XLEN-1]);
    endfunction

endpackage

// File: rtl/cpu_multi_cycle_reg_file_2r1w.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// synchronous clear; r0 is hardwired to zero.
module reg_file_2r1w
    import cpu_multi_cycle_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    output logic [XLEN-1:0]   rd1_o,
    output logic [XLEN-1:0]   rd2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [XLEN-1:0]   wd_i
);

    logic [XLEN-1:0] rf_q [NREGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            rf_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : rf_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : rf_q[ra2_i];

endmodule

// File: rtl/cpu_multi_cycle.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP
// state; one instruction in flight, single request/ready memory port.
module cpu_multi_cycle
    import cpu_multi_cycle_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       pc_o,
    output logic              retire_o,
    output logic              halted_o,
    output logic [1:0]        trap_cause_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cause_q, cause_d;

    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_val, rt_val;

    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [31:0]       rf_wd;

    logic signed [31:0] a_s, b_s, imm_s;
    logic signed [31:0] sum_rr, diff_rr, sum_ri;
    logic [31:0] alu_res, pc_plus4, br_tgt, j_tgt, addr_full;
    logic        ovf, is_jr, mem_req, mem_we, retire;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign funct = ir_q[5:0];
    assign is_jr = (op == OP_RTYPE) && (funct == FN_JR);

    reg_file_2r1w u_rf (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_val),
        .rd2_o (rt_val),
        .we_i  (rf_we),
        .wa_i  (rf_wa),
        .wd_i  (rf_wd)
    );

    assign a_s      = a_q;
    assign b_s      = b_q;
    assign imm_s    = imm_q;
    assign sum_rr   = a_s + b_s;
    assign diff_rr  = a_s - b_s;
    assign sum_ri   = a_s + imm_s;
    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = pc_plus4 + {imm_q[29:0], 2'b00};
    assign j_tgt    = {pc_plus4[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        alu_res = sum_rr;
                        ovf     = add_ovf(a_s, b_s, sum_rr);
                    end
                    FN_SUB: begin
                        alu_res = diff_rr;
                        ovf     = sub_ovf(a_s, b_s, diff_rr);
                    end
                    FN_AND:  alu_res = a_q & b_q;
                    FN_OR:   alu_res = a_q | b_q;
                    FN_SLT:  alu_res = {31'd0, (a_s < b_s)};
                    FN_SLL:  alu_res = b_q << shamt;
                    FN_SRL:  alu_res = b_q >> shamt;
                    FN_JR:   alu_res = a_q;
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI: begin
                alu_res = sum_ri;
                ovf     = add_ovf(a_s, imm_s, sum_ri);
            end
            OP_SLTI:      alu_res = {31'd0, (a_s < imm_s)};
            OP_LW, OP_SW: alu_res = sum_ri;
            OP_JAL:       alu_res = pc_plus4;
            default:      alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_full = pc_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready_i) begin
                    ir_d    = mem_rdata_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
                if (!is_legal(op, funct)) begin
                    cause_d = TRAP_ILLEGAL;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_res;
                // Trap checks come first so a faulting instruction never touches PC.
                if (ovf) begin
                    cause_d = TRAP_OVF;
                    state_d = S_TRAP;
                end else if (((op == OP_LW) || (op == OP_SW)) && (alu_res[1:0] != 2'b00)) begin
                    cause_d = TRAP_MISALIGN;
                    state_d = S_TRAP;
                end else if (is_jr && (a_q[1:0] != 2'b00)) begin
                    cause_d = TRAP_MISALIGN;
                    state_d = S_TRAP;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_d = S_MEM;
                end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
                    pc_d    = ((a_q == b_q) == (op == OP_BEQ)) ? br_tgt : pc_plus4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (op == OP_J) begin
                    pc_d    = j_tgt;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_d    = a_q;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (op == OP_SW);
                addr_full = alu_q;
                if (mem_ready_i) begin
                    if (op == OP_SW) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata_i;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
                pc_d   = pc_plus4;
                if (op == OP_RTYPE) begin
                    rf_wa = rd;
                    rf_wd = alu_q;
                end else if (op == OP_JAL) begin
                    rf_wa = 5'd31;
                    rf_wd = alu_q;
                    pc_d  = j_tgt;
                end else if (op == OP_LW) begin
                    rf_wa = rt;
                    rf_wd = mdr_q;
                end else begin
                    rf_wa = rt;
                    rf_wd = alu_q;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk_i) begin
        ir_q  <= ir_d;
        a_q   <= a_d;
        b_q   <= b_d;
        imm_q <= imm_d;
        alu_q <= alu_d;
        mdr_q <= mdr_d;
    end

    // Requests and retire are masked while reset is held so nothing leaks out mid-reset.
    assign mem_req_o    = mem_req & ~rst_i;
    assign mem_we_o     = mem_we & ~rst_i;
    assign mem_addr_o   = addr_full[ADDR_W-1:0];
    assign mem_wdata_o  = b_q;
    assign pc_o         = pc_q;
    assign retire_o     = retire & ~rst_i;
    assign halted_o     = (state_q == S_TRAP);
    assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_cpu_multi_cycle.sv
// Directed bench for cpu_multi_cycle: small programs in a word memory with
// configurable ready latency, hand-computed register, PC, bus and timing results.
module tb_cpu_multi_cycle;

    logic        clk_i;
    logic        rst_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] pc_o;
    logic        retire_o;
    logic        halted_o;
    logic [1:0]  trap_cause_o;

    cpu_multi_cycle #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rdata_i  (mem_rdata_i),
        .pc_o         (pc_o),
        .retire_o     (retire_o),
        .halted_o     (halted_o),
        .trap_cause_o (trap_cause_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int          n_vec  = 0;
    int          n_miss = 0;
    int          lat    = 0;
    logic        load_req = 1'b0;
    logic [31:0] img [256];
    logic [31:0] mem [256];
    int          wcnt = 0;
    logic [31:0] h_addr, h_wdata, st_addr, st_data;
    logic        h_we;
    logic        stab_err = 1'b0;
    int          n_st = 0;
    logic [31:0] acc_addr [$];
    int          cyc = 0;
    int          ret_q [$];

    assign mem_ready_i = mem_req_o && (wcnt >= lat);
    assign mem_rdata_i = mem[mem_addr_o[9:2]];

    always @(posedge clk_i) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end
        if (rst_i) begin
            wcnt     <= 0;
            n_st     <= 0;
            stab_err <= 1'b0;
            acc_addr.delete();
        end else if (mem_req_o) begin
            if (wcnt != 0 && (mem_addr_o !== h_addr || mem_wdata_o !== h_wdata || mem_we_o !== h_we))
                stab_err <= 1'b1;
            h_addr  <= mem_addr_o;
            h_wdata <= mem_wdata_o;
            h_we    <= mem_we_o;
            if (mem_ready_i) begin
                wcnt <= 0;
                acc_addr.push_back(mem_addr_o);
                if (mem_we_o) begin
                    mem[mem_addr_o[9:2]] <= mem_wdata_o;
                    st_addr <= mem_addr_o;
                    st_data <= mem_wdata_o;
                    n_st    <= n_st + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // Cycle 1 is the first cycle with reset low; retire cycles are logged on that scale.
    always @(negedge clk_i) begin
        if (rst_i) begin
            cyc <= 0;
            ret_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (retire_o) ret_q.push_back(cyc + 1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    function automatic logic [31:0] rf(input int i);
        return dut.u_rf.rf_q[i];
    endfunction

    task automatic clr_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        img[a[9:2]] = w;
    endtask

    task automatic load_prog();
        load_req = 1'b1;
        @(posedge clk_i);
        #1 load_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
        chk("rst_pc",    pc_o, 32'h0000_0000);
        chk("rst_halt",  {31'd0, halted_o}, 32'd0);
        chk("rst_cause", {30'd0, trap_cause_o}, 32'd0);
        chk("rst_ret",   {31'd0, retire_o}, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic run_ret(input int n, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk_i);
            if (ret_q.size() >= n) break;
        end
        chk("ret_timeout", {31'd0, k < budget}, 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic run_halt(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk_i);
            if (halted_o) break;
        end
        chk("halt_timeout", {31'd0, k < budget}, 32'd1);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic chk_ret(input int idx, input int exp);
        chk($sformatf("ret_cyc%0d", idx), (ret_q.size() > idx) ? ret_q[idx] : -1, exp);
    endtask

    task automatic chk_acc(input int idx, input logic [31:0] exp);
        chk($sformatf("acc%0d", idx), (acc_addr.size() > idx) ? acc_addr[idx] : 32'hDEAD_BEEF, exp);
    endtask

    initial begin
        int k;
        rst_i = 1'b1;

        // ALU chain, r0 write, back-to-back latency with ready tied high
        clr_img();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(32'h08, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        put(32'h0C, enc_i(6'h08, 5'd0, 5'd0, 16'd9));
        put(32'h10, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        lat = 0;
        load_prog();
        do_reset();
        run_ret(4, 100);
        chk_ret(0, 4); chk_ret(1, 8); chk_ret(2, 12); chk_ret(3, 16);
        chk("r1", rf(1), 32'd5);
        chk("r2", rf(2), 32'd7);
        chk("r3_add", rf(3), 32'd12);
        chk("r0_zero", rf(0), 32'd0);

        // store then load with 3 wait cycles per access
        clr_img();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd3, 16'd12));
        put(32'h04, enc_i(6'h2B, 5'd0, 5'd3, 16'h0010));
        put(32'h08, enc_i(6'h23, 5'd0, 5'd4, 16'h0010));
        put(32'h0C, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        lat = 3;
        load_prog();
        do_reset();
        run_ret(3, 200);
        chk_ret(0, 7); chk_ret(1, 17); chk_ret(2, 28);
        chk("st_addr", st_addr, 32'h10);
        chk("st_data", st_data, 32'd12);
        chk("st_count", n_st, 32'd1);
        chk("st_stable", {31'd0, stab_err}, 32'd0);
        chk("r4_lw", rf(4), 32'd12);

        // control flow: j, beq taken, bne not taken, jal, jr
        clr_img();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
        put(32'h04, enc_j(6'h02, 26'h8));
        put(32'h20, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
        put(32'h24, enc_i(6'h08, 5'd0, 5'd5, 16'd99));
        put(32'h2C, enc_i(6'h05, 5'd1, 5'd1, 16'd5));
        put(32'h30, enc_j(6'h03, 26'h40));
        put(32'h34, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        put(32'h100, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
        lat = 0;
        load_prog();
        do_reset();
        run_ret(6, 200);
        chk_acc(0, 32'h00); chk_acc(1, 32'h04); chk_acc(2, 32'h20); chk_acc(3, 32'h2C);
        chk_acc(4, 32'h30); chk_acc(5, 32'h100); chk_acc(6, 32'h34);
        chk_ret(0, 4); chk_ret(1, 7); chk_ret(2, 10); chk_ret(3, 13); chk_ret(4, 17); chk_ret(5, 20);
        chk("r31_jal", rf(31), 32'h34);
        chk("r5_skipped", rf(5), 32'd0);

        // ALU coverage with signed operands
        clr_img();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'h00F0));
        put(32'h08, enc_r(5'd2, 5'd1, 5'd3, 5'd0, 6'h22));
        put(32'h0C, enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h24));
        put(32'h10, enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h25));
        put(32'h14, enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h2A));
        put(32'h18, enc_i(6'h0A, 5'd2, 5'd7, 16'hFFFF));
        put(32'h1C, enc_r(5'd0, 5'd2, 5'd8, 5'd4, 6'h00));
        put(32'h20, enc_r(5'd0, 5'd1, 5'd9, 5'd28, 6'h02));
        put(32'h24, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        load_prog();
        do_reset();
        run_ret(9, 200);
        chk("r1_neg", rf(1), 32'hFFFF_FFFD);
        chk("r3_sub", rf(3), 32'h0000_00F3);
        chk("r4_and", rf(4), 32'h0000_00F0);
        chk("r5_or",  rf(5), 32'hFFFF_FFFD);
        chk("r6_slt", rf(6), 32'd1);
        chk("r7_slti", rf(7), 32'd0);
        chk("r8_sll", rf(8), 32'h0000_0F00);
        chk("r9_srl", rf(9), 32'h0000_000F);

        // illegal opcode (lui)
        clr_img();
        put(32'h00, 32'h3C01_0001);
        load_prog();
        do_reset();
        run_halt(50);
        chk("ill_halt", {31'd0, halted_o}, 32'd1);
        chk("ill_cause", {30'd0, trap_cause_o}, 32'd1);
        chk("ill_ret", ret_q.size(), 32'd0);
        chk("ill_pc", pc_o, 32'h0);
        chk("ill_req", {31'd0, mem_req_o}, 32'd0);

        // signed overflow on add leaves rd untouched
        clr_img();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF));
        put(32'h04, enc_r(5'd0, 5'd1, 5'd1, 5'd1, 6'h02));
        put(32'h08, enc_i(6'h08, 5'd0, 5'd2, 16'd1));
        put(32'h0C, enc_i(6'h08, 5'd0, 5'd3, 16'h0055));
        put(32'h10, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        load_prog();
        do_reset();
        run_halt(100);
        chk("ovf_r1", rf(1), 32'h7FFF_FFFF);
        chk("ovf_cause", {30'd0, trap_cause_o}, 32'd2);
        chk("ovf_r3", rf(3), 32'h0000_0055);
        chk("ovf_pc", pc_o, 32'h10);
        chk("ovf_ret", ret_q.size(), 32'd4);

        // misaligned load never reaches the bus
        clr_img();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'h0011));
        put(32'h04, enc_i(6'h23, 5'd1, 5'd2, 16'h0000));
        load_prog();
        do_reset();
        run_halt(50);
        chk("mis_cause", {30'd0, trap_cause_o}, 32'd3);
        chk("mis_acc", acc_addr.size(), 32'd2);
        chk("mis_r2", rf(2), 32'd0);
        chk("mis_pc", pc_o, 32'h4);
        chk("mis_req", {31'd0, mem_req_o}, 32'd0);

        // misaligned jr target
        clr_img();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd6));
        put(32'h04, enc_r(5'd1, 5'd0, 5'd0, 5'd0, 6'h08));
        load_prog();
        do_reset();
        run_halt(50);
        chk("jr_cause", {30'd0, trap_cause_o}, 32'd3);
        chk("jr_pc", pc_o, 32'h4);

        // reset asserted while a store waits for ready
        clr_img();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h04, enc_i(6'h2B, 5'd0, 5'd1, 16'h0010));
        put(32'h08, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        lat = 3;
        load_prog();
        do_reset();
        for (k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (mem_req_o && mem_we_o) break;
        end
        chk("sw_wait_seen", {31'd0, k < 100}, 32'd1);
        chk("pre_rst_r1", rf(1), 32'd5);
        do_reset();
        chk("mid_rst_r1", rf(1), 32'd0);
        chk("mid_rst_mem", mem[4], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
